// File: rtl/raisin64_pkg.sv
// Shared Raisin64 definitions: datapath widths, execute-unit indices and the
// commit-stage state and queue-entry types.
package raisin64_pkg;

  localparam int RN_W   = 6;
  localparam int DATA_W = 64;

  localparam int UNIT_ALU1    = 0;
  localparam int UNIT_ALU2    = 1;
  localparam int UNIT_ADVINT  = 2;
  localparam int UNIT_MEMUNIT = 3;

  typedef enum logic {
    PICK   = 1'b0,
    SECOND = 1'b1
  } commit_state_e;

  typedef struct packed {
    logic [RN_W-1:0]   rd_rn;
    logic [DATA_W-1:0] data;
    logic              rd2_en;
    logic [RN_W-1:0]   rd2_rn;
    logic [DATA_W-1:0] data2;
  } commit_entry_t;

endpackage

// File: rtl/commit_fifo.sv
// Small synchronous result queue; pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate count.
module commit_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only ever read while valid.
  always_ff @(posedge clk) begin
    if (push_i && !full_o && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/commit.sv
// Raisin64 commit stage: per-unit result queues arbitrated onto the single
// register-file write port. Define COMMIT_RR_ARB_EN for round-robin grants.
module commit
  import raisin64_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int DEPTH     = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_UNITS-1:0]        res_valid,
  output logic [NUM_UNITS-1:0]        res_ready,
  input  logic [RN_W*NUM_UNITS-1:0]   res_rd_rn,
  input  logic [DATA_W*NUM_UNITS-1:0] res_data,
  input  logic [NUM_UNITS-1:0]        res_rd2_en,
  input  logic [RN_W*NUM_UNITS-1:0]   res_rd2_rn,
  input  logic [DATA_W*NUM_UNITS-1:0] res_data2,
  input  logic                        flush,
  output logic                        w_en,
  output logic [RN_W-1:0]             w_rn,
  output logic [DATA_W-1:0]           w_data,
  output logic                        free_en,
  output logic [RN_W-1:0]             free_rn,
  output logic                        busy
);

  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int EW = $bits(commit_entry_t);

  commit_entry_t        head [NUM_UNITS];
  logic [NUM_UNITS-1:0] full, empty, push, pop;
  commit_state_e        state_q;
  logic [UW-1:0]        lock_q, grant, cand, sel;
  logic                 grant_valid, slot_valid;
  commit_entry_t        sel_entry;
  logic [RN_W-1:0]      slot_rn;
  logic [DATA_W-1:0]    slot_data;
  logic                 w_en_q, free_en_q;
  logic [RN_W-1:0]      w_rn_q, free_rn_q;
  logic [DATA_W-1:0]    w_data_q;
`ifdef COMMIT_RR_ARB_EN
  logic [UW-1:0]        rr_q;
`endif

  assign res_ready = ~full & {NUM_UNITS{~flush}};
  assign push      = res_valid & res_ready;

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
    commit_entry_t din;
    assign din = '{rd_rn:  res_rd_rn[i*RN_W +: RN_W],
                   data:   res_data[i*DATA_W +: DATA_W],
                   rd2_en: res_rd2_en[i],
                   rd2_rn: res_rd2_rn[i*RN_W +: RN_W],
                   data2:  res_data2[i*DATA_W +: DATA_W]};

    commit_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .flush_i (flush),
      .din_i   (din),
      .full_o  (full[i]),
      .empty_o (empty[i]),
      .head_o  (head[i])
    );
  end

  // Candidate order: fixed lowest-index first, or rotating from last grant + 1.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    cand        = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
`ifdef COMMIT_RR_ARB_EN
      cand = UW'((int'(rr_q) + 1 + k) % NUM_UNITS);
`else
      cand = UW'(k);
`endif
      if (!grant_valid && !empty[cand]) begin
        grant_valid = 1'b1;
        grant       = cand;
      end
    end
  end

  always_comb begin
    sel        = (state_q == SECOND) ? lock_q : grant;
    sel_entry  = head[sel];
    slot_valid = !flush && ((state_q == SECOND) || grant_valid);
    slot_rn    = (state_q == SECOND) ? sel_entry.rd2_rn : sel_entry.rd_rn;
    slot_data  = (state_q == SECOND) ? sel_entry.data2  : sel_entry.data;
    pop        = '0;
    if (slot_valid && ((state_q == SECOND) || !sel_entry.rd2_en)) pop[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PICK;
      lock_q    <= '0;
      w_en_q    <= 1'b0;
      w_rn_q    <= '0;
      w_data_q  <= '0;
      free_en_q <= 1'b0;
      free_rn_q <= '0;
    end else begin
      free_en_q <= w_en_q;
      free_rn_q <= w_rn_q;
      // A slot targeting r0 still burns the cycle but never reaches the file.
      w_en_q    <= slot_valid && (slot_rn != '0);
      if (slot_valid && (slot_rn != '0)) begin
        w_rn_q   <= slot_rn;
        w_data_q <= slot_data;
      end
      if (flush) begin
        state_q <= PICK;
      end else begin
        case (state_q)
          PICK: begin
            if (grant_valid && sel_entry.rd2_en) begin
              state_q <= SECOND;
              lock_q  <= grant;
            end
          end
          SECOND:  state_q <= PICK;
          default: state_q <= PICK;
        endcase
      end
    end
  end

`ifdef COMMIT_RR_ARB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= UW'(NUM_UNITS - 1);
    end else if (!flush && (state_q == PICK) && grant_valid) begin
      rr_q <= grant;
    end
  end
`endif

  assign w_en    = w_en_q;
  assign w_rn    = w_rn_q;
  assign w_data  = w_data_q;
  assign free_en = free_en_q;
  assign free_rn = free_rn_q;
  assign busy    = (|(~empty)) || (state_q == SECOND);

endmodule

// File: tb/tb_commit.sv
// Self-checking bench for commit: randomized and directed scenarios against a
// queue-based behavioural model of the commit rules.
module tb_commit;

  localparam int NU    = 4;
  localparam int DEPTH = 2;

  logic          clk, rst_n, flush;
  logic [NU-1:0] res_valid, res_ready, res_rd2_en;
  logic [6*NU-1:0]  res_rd_rn, res_rd2_rn;
  logic [64*NU-1:0] res_data, res_data2;
  logic          w_en, free_en, busy;
  logic [5:0]    w_rn, free_rn;
  logic [63:0]   w_data;

  commit #(.NUM_UNITS(NU), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_ready(res_ready),
    .res_rd_rn(res_rd_rn), .res_data(res_data), .res_rd2_en(res_rd2_en),
    .res_rd2_rn(res_rd2_rn), .res_data2(res_data2), .flush(flush),
    .w_en(w_en), .w_rn(w_rn), .w_data(w_data), .free_en(free_en),
    .free_rn(free_rn), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  rn;
    logic [63:0] data;
    logic        rd2_en;
    logic [5:0]  rn2;
    logic [63:0] data2;
  } ent_t;

  ent_t mq [NU][$];
  bit   pend;
  int   lock_u, last_u;
  logic m_wen, m_fen;
  logic [5:0]  m_wrn, m_frn;
  logic [63:0] m_wdata;
  logic [NU-1:0] exp_ready, obs_ready;
  logic [82:0] obs_v, exp_v;
  localparam logic [82:0] RESET_V = {1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 1'b0, 4'hF};

  int n_checks = 0;
  int n_pass   = 0;

  function automatic bit m_busy();
    bit b = pend;
    for (int i = 0; i < NU; i++) if (mq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NU; i++) mq[i].delete();
    pend = 0; lock_u = 0; last_u = NU - 1;
    m_wen = 0; m_wrn = 0; m_wdata = 0; m_fen = 0; m_frn = 0;
  endtask

  task automatic clear_inputs();
    res_valid = '0; res_rd2_en = '0; res_rd_rn = '0; res_rd2_rn = '0;
    res_data = '0; res_data2 = '0; flush = 1'b0;
  endtask

  task automatic set_unit(input int i, input logic [5:0] rn, input logic [63:0] d,
                          input logic e2, input logic [5:0] rn2, input logic [63:0] d2);
    res_valid[i] = 1'b1;
    res_rd_rn[i*6 +: 6] = rn;   res_data[i*64 +: 64] = d;
    res_rd2_en[i] = e2;
    res_rd2_rn[i*6 +: 6] = rn2; res_data2[i*64 +: 64] = d2;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Advances one clock: the model decides this edge's write slot from the
  // queue contents before the edge, then takes any accepted pushes.
  task automatic tick();
    bit   acc [NU];
    ent_t e, ne;
    int   u, cand;
    bit   slot;
    logic [5:0]  rn;
    logic [63:0] d;
    #1;
    for (int i = 0; i < NU; i++) begin
      exp_ready[i] = (mq[i].size() < DEPTH) && !flush;
      acc[i] = res_valid[i] && exp_ready[i];
    end
    obs_ready = res_ready;
    m_fen = m_wen; m_frn = m_wrn; m_wen = 0;
    slot = 0; rn = 0; d = 0;
    if (flush) begin
      for (int i = 0; i < NU; i++) mq[i].delete();
      pend = 0;
    end else if (pend) begin
      e = mq[lock_u].pop_front();
      rn = e.rn2; d = e.data2; slot = 1; pend = 0;
    end else begin
      u = -1;
      for (int k = 0; k < NU; k++) begin
`ifdef COMMIT_RR_ARB_EN
        cand = (last_u + 1 + k) % NU;
`else
        cand = k;
`endif
        if (u < 0 && mq[cand].size() > 0) u = cand;
      end
      if (u >= 0) begin
        e = mq[u][0];
        rn = e.rn; d = e.data; slot = 1; last_u = u;
        if (e.rd2_en) begin pend = 1; lock_u = u; end
        else void'(mq[u].pop_front());
      end
    end
    if (slot && rn != 0) begin m_wen = 1; m_wrn = rn; m_wdata = d; end
    for (int i = 0; i < NU; i++) if (acc[i]) begin
      ne.rn = res_rd_rn[i*6 +: 6];   ne.data = res_data[i*64 +: 64];
      ne.rd2_en = res_rd2_en[i];
      ne.rn2 = res_rd2_rn[i*6 +: 6]; ne.data2 = res_data2[i*64 +: 64];
      mq[i].push_back(ne);
    end
    @(posedge clk); #1;
    obs_v = {w_en, w_en ? w_rn : 6'd0, w_en ? w_data : 64'd0,
             free_en, free_en ? free_rn : 6'd0, busy, obs_ready};
    exp_v = {m_wen, m_wen ? m_wrn : 6'd0, m_wen ? m_wdata : 64'd0,
             m_fen, m_fen ? m_frn : 6'd0, m_busy(), exp_ready};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #2;
    n_checks++;
    if ({w_en, w_rn, w_data, free_en, free_rn, busy, res_ready} !== RESET_V)
      $display("[TB] FAIL reset_values got=%h want=%h",
               {w_en, w_rn, w_data, free_en, free_rn, busy, res_ready}, RESET_V);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    set_unit(0, 6'd5, 64'h1234, 1'b0, 6'd0, 64'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c == 0) clear_inputs();
      n_checks++;
      if (obs_v !== exp_v) $display("[TB] FAIL single c%0d got=%h want=%h", c, obs_v, exp_v);
      else n_pass++;
      if (c == 1) begin
        n_checks++;
        if ({w_en, w_rn, w_data} !== {1'b1, 6'd5, 64'h1234})
          $display("[TB] FAIL single_write got=%h want=%h", {w_en, w_rn, w_data}, {1'b1, 6'd5, 64'h1234});
        else n_pass++;
      end
      if (c == 2) begin
        n_checks++;
        if ({free_en, free_rn, busy} !== {1'b1, 6'd5, 1'b0})
          $display("[TB] FAIL single_free got=%h want=%h", {free_en, free_rn, busy}, {1'b1, 6'd5, 1'b0});
        else n_pass++;
      end
    end
  endtask

  task automatic test_all_units();
    int log_q[$];
    apply_reset();
    for (int i = 0; i < NU; i++) set_unit(i, 6'(i + 1), 64'(100 + i), 1'b0, 6'd0, 64'd0);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 0) clear_inputs();
      log_q.push_back(w_en ? int'(w_rn) : 0);
      n_checks++;
      if (obs_v !== exp_v) $display("[TB] FAIL all_units c%0d got=%h want=%h", c, obs_v, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (log_q != '{0, 1, 2, 3, 4, 0})
      $display("[TB] FAIL all_units_order got=%p want=0 1 2 3 4 0", log_q);
    else n_pass++;
  endtask

  task automatic test_second();
    int log_q[$];
    apply_reset();
    set_unit(2, 6'd10, 64'hA, 1'b1, 6'd11, 64'hB);
    set_unit(0, 6'd3, 64'h3, 1'b0, 6'd0, 64'd0);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 0) clear_inputs();
      if (w_en) log_q.push_back(int'(w_rn));
      n_checks++;
      if (obs_v !== exp_v) $display("[TB] FAIL second c%0d got=%h want=%h", c, obs_v, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (log_q != '{3, 10, 11})
      $display("[TB] FAIL second_order got=%p want=3 10 11", log_q);
    else n_pass++;
  endtask

  task automatic test_stream();
    int log_q[$];
    int n7;
    bit alt_ok, seen0, seen1;
    apply_reset();
    n7 = 0; alt_ok = 1; seen0 = 0; seen1 = 0;
    for (int c = 0; c < 16; c++) begin
      set_unit(0, 6'($urandom_range(63, 8)), {$urandom, $urandom}, 1'b0, 6'd0, 64'd0);
      set_unit(1, 6'd7, 64'h77, 1'b0, 6'd0, 64'd0);
      tick();
      if (!obs_ready[0]) seen0 = 1;
      if (!obs_ready[1]) seen1 = 1;
      if (w_en) begin log_q.push_back(int'(w_rn)); if (w_rn == 6'd7) n7++; end
      n_checks++;
      if (obs_v !== exp_v) $display("[TB] FAIL stream c%0d got=%h want=%h", c, obs_v, exp_v);
      else n_pass++;
    end
    clear_inputs();
    for (int j = 0; j + 1 < log_q.size(); j++)
      if ((log_q[j] == 7) == (log_q[j+1] == 7)) alt_ok = 0;
`ifdef COMMIT_RR_ARB_EN
    n_checks++;
    if (!(alt_ok && seen0 && log_q.size() >= 12))
      $display("[TB] FAIL stream_rr got alt=%0d ready0_drop=%0d writes=%0d want 1 1 >=12", alt_ok, seen0, log_q.size());
    else n_pass++;
`else
    n_checks++;
    if (!(n7 == 0 && seen1 && !seen0))
      $display("[TB] FAIL stream_fixed got rd7_writes=%0d ready1_drop=%0d ready0_drop=%0d want 0 1 0", n7, seen1, seen0);
    else n_pass++;
`endif
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++;
      if (obs_v !== exp_v) $display("[TB] FAIL stream_drain c%0d got=%h want=%h", c, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_zero_reg();
    apply_reset();
    set_unit(0, 6'd0, 64'hDEAD, 1'b0, 6'd0, 64'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 0) clear_inputs();
      n_checks++;
      if (obs_v !== exp_v) $display("[TB] FAIL zero c%0d got=%h want=%h", c, obs_v, exp_v);
      else n_pass++;
      n_checks++;
      if ({w_en, free_en, busy} !== {1'b0, 1'b0, (c == 0)})
        $display("[TB] FAIL zero_flags c%0d got=%b want=%b", c, {w_en, free_en, busy}, {1'b0, 1'b0, (c == 0)});
      else n_pass++;
    end
  endtask

  // Queues a two-write result plus two singles, then returns with the
  // second write pending and the first already on w_*.
  task automatic load_pending_second();
    apply_reset();
    set_unit(0, 6'd20, 64'h20, 1'b1, 6'd21, 64'h21);
    set_unit(1, 6'd22, 64'h22, 1'b0, 6'd0, 64'd0);
    set_unit(3, 6'd23, 64'h23, 1'b0, 6'd0, 64'd0);
    tick();
    clear_inputs();
    tick();
    n_checks++;
    if ({w_en, w_rn, busy} !== {1'b1, 6'd20, 1'b1})
      $display("[TB] FAIL pending_setup got=%h want=%h", {w_en, w_rn, busy}, {1'b1, 6'd20, 1'b1});
    else n_pass++;
  endtask

  task automatic test_flush();
    load_pending_second();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if ({w_en, free_en, free_rn, busy} !== {1'b0, 1'b1, 6'd20, 1'b0})
      $display("[TB] FAIL flush_cycle got=%h want=%h", {w_en, free_en, free_rn, busy}, {1'b0, 1'b1, 6'd20, 1'b0});
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (obs_v !== exp_v) $display("[TB] FAIL flush c%0d got=%h want=%h", c, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    load_pending_second();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({w_en, w_rn, w_data, free_en, free_rn, busy, res_ready} !== RESET_V)
      $display("[TB] FAIL reset_mid got=%h want=%h",
               {w_en, w_rn, w_data, free_en, free_rn, busy, res_ready}, RESET_V);
    else n_pass++;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (obs_v !== exp_v) $display("[TB] FAIL reset_mid c%0d got=%h want=%h", c, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      clear_inputs();
      for (int i = 0; i < NU; i++)
        if ($urandom_range(1, 0) == 1)
          set_unit(i, 6'($urandom_range(63, 0)), {$urandom, $urandom},
                   ($urandom_range(3, 0) == 0), 6'($urandom_range(63, 0)), {$urandom, $urandom});
      flush = ($urandom_range(15, 0) == 0);
      tick();
      n_checks++;
      if (obs_v !== exp_v) $display("[TB] FAIL random c%0d got=%h want=%h", c, obs_v, exp_v);
      else n_pass++;
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_units();
    test_second();
    test_stream();
    test_zero_reg();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
